// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared encodings for the traffic phase scheduler: lamp codes, phase
// states, approach directions and the lamp decode helpers.
package traffic_phase_scheduler_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALLRED_A  = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_ALLRED_B  = 3'd5,
        ST_WALK      = 3'd6
    } phase_e;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;

    function automatic logic [2:0] ns_lamp(input phase_e s);
        case (s)
            ST_NS_GREEN:  ns_lamp = LIGHT_GREEN;
            ST_NS_YELLOW: ns_lamp = LIGHT_YELLOW;
            default:      ns_lamp = LIGHT_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input phase_e s);
        case (s)
            ST_EW_GREEN:  ew_lamp = LIGHT_GREEN;
            ST_EW_YELLOW: ew_lamp = LIGHT_YELLOW;
            default:      ew_lamp = LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Elapsed-tick counter for the current phase. Clear has priority over the
// tick; the count saturates at all-ones so a resting green cannot wrap.
module traffic_phase_scheduler_phase_timer #(
    parameter int TICK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              tick_i,
    output logic [TICK_W-1:0] count_o
);

    logic [TICK_W-1:0] count_q, count_d;

    // Next count: clear on phase change, otherwise saturating increment on tick
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != {TICK_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, asynchronously cleared by active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated two-road phase scheduler with min/max green, yellow and
// all-red clearance. All timing advances only on cycles with tick=1.
// Optional pedestrian walk phase enabled by defining PED_WALK_EN.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int TICK_W    = 4,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              ns_req,
    input  logic              ew_req,
    input  logic              ped_req,
    output logic [2:0]        ns_light,
    output logic [2:0]        ew_light,
    output logic              walk,
    output logic [TICK_W-1:0] phase_ticks
);

    // Last-tick values: a phase of length D exits on the tick seen at D-1
    localparam logic [TICK_W-1:0] GMIN_LAST = TICK_W'(GREEN_MIN - 1);
    localparam logic [TICK_W-1:0] GMAX_LAST = TICK_W'(GREEN_MAX - 1);
    localparam logic [TICK_W-1:0] YEL_LAST  = TICK_W'(YELLOW_T - 1);
    localparam logic [TICK_W-1:0] AR_LAST   = TICK_W'(ALLRED_T - 1);
    localparam logic [TICK_W-1:0] WALK_LAST = TICK_W'(WALK_T - 1);

    phase_e            state_q, state_d;
    dir_e              last_dir_q, last_dir_d;
    logic              ped_pend_q, ped_pend_d;
    logic [2:0]        ns_light_q, ew_light_q;
    logic [TICK_W-1:0] ticks;
    logic              phase_change;

    assign phase_change = (state_d != state_q);

    traffic_phase_scheduler_phase_timer #(
        .TICK_W (TICK_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (phase_change),
        .tick_i  (tick),
        .count_o (ticks)
    );

    // Next-state and last-direction logic; unknown encodings recover to ALLRED_B
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        case (state_q)
            ST_NS_GREEN: begin
                if (tick && (ticks >= GMIN_LAST) && (ew_req || ped_pend_q) &&
                    (!ns_req || (ticks >= GMAX_LAST))) begin
                    state_d = ST_NS_YELLOW;
                end
            end
            ST_NS_YELLOW: begin
                if (tick && (ticks == YEL_LAST)) state_d = ST_ALLRED_A;
            end
            ST_ALLRED_A: begin
                if (tick && (ticks == AR_LAST)) state_d = ped_pend_q ? ST_WALK : ST_EW_GREEN;
            end
            ST_EW_GREEN: begin
                if (tick && (ticks >= GMIN_LAST) && (ns_req || ped_pend_q) &&
                    (!ew_req || (ticks >= GMAX_LAST))) begin
                    state_d = ST_EW_YELLOW;
                end
            end
            ST_EW_YELLOW: begin
                if (tick && (ticks == YEL_LAST)) state_d = ST_ALLRED_B;
            end
            ST_ALLRED_B: begin
                if (tick && (ticks == AR_LAST)) state_d = ped_pend_q ? ST_WALK : ST_NS_GREEN;
            end
            ST_WALK: begin
                // Serve the road that did not have the most recent green
                if (tick && (ticks == WALK_LAST)) begin
                    state_d = (last_dir_q == DIR_NS) ? ST_EW_GREEN : ST_NS_GREEN;
                end
            end
            default: state_d = ST_ALLRED_B;
        endcase

        if ((state_d == ST_NS_GREEN) && (state_q != ST_NS_GREEN)) last_dir_d = DIR_NS;
        if ((state_d == ST_EW_GREEN) && (state_q != ST_EW_GREEN)) last_dir_d = DIR_EW;
    end

`ifdef PED_WALK_EN
    logic walk_q;

    // Pedestrian latch: a new press in the WALK-entry cycle keeps it pending
    always_comb begin
        ped_pend_d = ped_pend_q;
        if ((state_d == ST_WALK) && (state_q != ST_WALK)) ped_pend_d = 1'b0;
        if (ped_req) ped_pend_d = 1'b1;
    end

    // Walk lamp registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            walk_q <= 1'b0;
        end else begin
            walk_q <= (state_d == ST_WALK);
        end
    end

    assign walk = walk_q;
`else
    logic ped_unused;

    // Without the walk phase the button has no effect and nothing is pending
    always_comb begin
        ped_pend_d = 1'b0;
    end

    assign ped_unused = ped_req;
    assign walk       = 1'b0;
`endif

    // State, direction memory, pedestrian latch and lamp registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_ALLRED_B;
            last_dir_q <= DIR_EW;
            ped_pend_q <= 1'b0;
            ns_light_q <= LIGHT_RED;
            ew_light_q <= LIGHT_RED;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            ped_pend_q <= ped_pend_d;
            ns_light_q <= ns_lamp(state_d);
            ew_light_q <= ew_lamp(state_d);
        end
    end

    assign ns_light    = ns_light_q;
    assign ew_light    = ew_light_q;
    assign phase_ticks = ticks;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: reset, resting green,
// demand-driven sequencing, max-green yield, reset during yellow and the
// pedestrian walk phase (expectations follow PED_WALK_EN).
module tb_traffic_phase_scheduler;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [3:0] phase_ticks;

    int n_checks;
    int n_fail;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ns_req      (ns_req),
        .ew_req      (ew_req),
        .ped_req     (ped_req),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .walk        (walk),
        .phase_ticks (phase_ticks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One tick cycle followed by one idle cycle; returns #1 after an edge
    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        @(posedge clk); #1;
        ped_req = 1'b0;
    endtask

    // Check lamps and elapsed count before each of n ticks of one phase
    task automatic run_phase(input string tag, input int n, input int start,
                             input logic [2:0] ns_e, input logic [2:0] ew_e, input logic wk_e);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_ns"}, ns_light, ns_e);
            chk({tag, "_ew"}, ew_light, ew_e);
            chk({tag, "_walk"}, walk, wk_e);
            chk({tag, "_pt"}, phase_ticks, start + i);
            pulse_tick();
        end
    endtask

    task automatic check_all_red(input string tag);
        chk({tag, "_ns"}, ns_light, RED);
        chk({tag, "_ew"}, ew_light, RED);
        chk({tag, "_walk"}, walk, 1'b0);
        chk({tag, "_pt"}, phase_ticks, 0);
    endtask

    // Asynchronous reset mid-cycle, checked before the next edge, then released
    task automatic mid_reset(input string tag);
        #3 rst = 1'b0;
        #1 check_all_red(tag);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        tick     = 1'b0;
        ns_req   = 1'b0;
        ew_req   = 1'b0;
        ped_req  = 1'b0;

        // Reset state, then ALLRED_B waits for a tick before NS green
        repeat (3) @(posedge clk);
        #1 check_all_red("rst");
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_red("rst_hold");
        pulse_tick();
        chk("rel_ns", ns_light, GRN);
        chk("rel_ew", ew_light, RED);

        // No demand: rest in NS green, count saturates
        run_phase("t2", 15, 0, GRN, RED, 1'b0);
        repeat (5) pulse_tick();
        chk("t2_sat_pt", phase_ticks, 15);
        chk("t2_sat_ns", ns_light, GRN);

        // Reset mid-run, release, one tick back to NS green
        mid_reset("t1_mid");
        pulse_tick();
        chk("t1_ns", ns_light, GRN);
        chk("t1_ew", ew_light, RED);

        // EW demand only: min green, yellow, all red, EW green
        ew_req = 1'b1;
        run_phase("t3_nsg", 5, 0, GRN, RED, 1'b0);
        run_phase("t3_nsy", 3, 0, YEL, RED, 1'b0);
        run_phase("t3_ar", 1, 0, RED, RED, 1'b0);
        chk("t3_ew", ew_light, GRN);
        chk("t3_ns", ns_light, RED);

        // Both roads demanding: each green runs to max then yields
        ns_req = 1'b1;
        run_phase("t4_ewg", 10, 0, RED, GRN, 1'b0);
        run_phase("t4_ewy", 3, 0, RED, YEL, 1'b0);
        run_phase("t4_arb", 1, 0, RED, RED, 1'b0);
        run_phase("t4_nsg", 10, 0, GRN, RED, 1'b0);
        run_phase("t4_nsy", 3, 0, YEL, RED, 1'b0);
        run_phase("t4_ara", 1, 0, RED, RED, 1'b0);

        // Reset during EW yellow with a pending ped press
        run_phase("t6_ewg", 10, 0, RED, GRN, 1'b0);
        run_phase("t6_ewy", 1, 0, RED, YEL, 1'b0);
        chk("t6_in_yel", ew_light, YEL);
        pulse_ped();
        mid_reset("t6_rst");
        ns_req = 1'b0;
        ew_req = 1'b0;
        pulse_tick();
        chk("t6_ns", ns_light, GRN);
        chk("t6_ew", ew_light, RED);
        run_phase("t6_hold", 8, 0, GRN, RED, 1'b0);
        chk("t6_hold_pt", phase_ticks, 8);

        // Pedestrian press at tick 2 of NS green
        mid_reset("t5_rst");
        pulse_tick();
        run_phase("t5_ns0", 2, 0, GRN, RED, 1'b0);
        pulse_ped();
`ifdef PED_WALK_EN
        run_phase("t5_ns1", 3, 2, GRN, RED, 1'b0);
        run_phase("t5_nsy", 3, 0, YEL, RED, 1'b0);
        run_phase("t5_ar", 1, 0, RED, RED, 1'b0);
        run_phase("t5_walk", 6, 0, RED, RED, 1'b1);
        chk("t5_ew", ew_light, GRN);
        chk("t5_ns", ns_light, RED);
        chk("t5_walk_off", walk, 1'b0);
`else
        run_phase("t5_hold", 10, 2, GRN, RED, 1'b0);
        chk("t5_hold_pt", phase_ticks, 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
